// File: rtl/bcd_pkg.sv
// Shared types, display codes and elaboration helpers for the sequential
// binary-to-BCD converter.
package bcd_pkg;

  localparam logic [3:0] SEG_MINUS = 4'hA;
  localparam logic [3:0] SEG_BLANK = 4'hF;

  typedef enum logic [0:0] {
    IDLE,
    CONVERT
  } conv_state_t;

  typedef logic [3:0] bcd_digit_t;

  // 10**n, saturating at all-ones so a huge digit count never flags overflow
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      if (r > 64'd1844674407370955161) r = '1;
      else                              r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift the
// incoming binary bit into the units position. The top carry is discarded.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 3
) (
  input  logic [4*NUM_DIGITS-1:0] i_bcd,
  input  logic                    i_bit,
  output logic [4*NUM_DIGITS-1:0] o_bcd
);

  logic [4*NUM_DIGITS-1:0] w_adj;

  always_comb begin
    w_adj = i_bcd;
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      if (bcd_digit_t'(i_bcd[4*d +: 4]) >= 4'd5)
        w_adj[4*d +: 4] = i_bcd[4*d +: 4] + 4'd3;
    end
  end

  assign o_bcd = (w_adj << 1) | {{(4*NUM_DIGITS-1){1'b0}}, i_bit};

endmodule

// File: rtl/segdec.sv
// Seven-segment decoder, segments {g,f,e,d,c,b,a} active high.
// Codes 0-9 are digits, 4'hA is a minus sign, everything else is blank.
module segdec (
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h00;
    case (i_code)
      4'h0:    o_seg = 7'h3F;
      4'h1:    o_seg = 7'h06;
      4'h2:    o_seg = 7'h5B;
      4'h3:    o_seg = 7'h4F;
      4'h4:    o_seg = 7'h66;
      4'h5:    o_seg = 7'h6D;
      4'h6:    o_seg = 7'h7D;
      4'h7:    o_seg = 7'h07;
      4'h8:    o_seg = 7'h7F;
      4'h9:    o_seg = 7'h6F;
      4'hA:    o_seg = 7'h40;
      default: o_seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (one bit per cycle) with sign handling,
// overflow flag and a seven-segment display of sign plus magnitude digits.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned IN_WIDTH      = 8,
  parameter int unsigned NUM_DIGITS    = 3,
  parameter int unsigned SIGNED        = 1,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_WIDTH-1:0]         in,
  output logic                        out_valid,
  output logic [4*NUM_DIGITS-1:0]     out_bcd,
  output logic                        out_sign,
  output logic                        overflow,
  output logic [NUM_DIGITS:0][6:0]    disp
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(IN_WIDTH);
  localparam int unsigned CMP_W = (IN_WIDTH > 64) ? IN_WIDTH : 64;
  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

  conv_state_t         r_state, w_next_state;
  logic [BCD_W-1:0]    r_scratch;
  logic [IN_WIDTH-1:0] r_mag;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_sign_p, r_ovf_p;
  logic                r_out_valid, r_out_sign, r_overflow;
  logic [BCD_W-1:0]    r_out_bcd;

  logic                w_ready, w_load, w_done, w_last;
  logic                w_sign, w_ovf;
  logic [IN_WIDTH-1:0] w_mag;
  logic [BCD_W-1:0]    w_step;

  // Most negative input wraps to its own bit pattern, which read unsigned is the magnitude
  assign w_sign = (SIGNED != 0) && in[IN_WIDTH-1];
  assign w_mag  = w_sign ? (~in + IN_WIDTH'(1)) : in;
  assign w_ovf  = CMP_W'(w_mag) >= CMP_W'(LIMIT);
  assign w_last = (r_cnt == '0);

  bcd_dabble_step #(.NUM_DIGITS(NUM_DIGITS)) u_step (
    .i_bcd (r_scratch),
    .i_bit (r_mag[IN_WIDTH-1]),
    .o_bcd (w_step)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = CONVERT;
      CONVERT: if (w_last)   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_ready = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE:    w_ready = 1'b1;
      CONVERT: w_done  = w_last;
      default: w_ready = 1'b0;
    endcase
    w_load = in_valid && w_ready;
  end

  // Datapath: capture, shift-and-add-3 iterations, result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scratch   <= '0;
      r_mag       <= '0;
      r_cnt       <= '0;
      r_sign_p    <= 1'b0;
      r_ovf_p     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_bcd   <= '0;
      r_out_sign  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= w_done;
      if (w_load) begin
        r_scratch <= '0;
        r_mag     <= w_mag;
        r_cnt     <= CNT_W'(IN_WIDTH - 1);
        r_sign_p  <= w_sign;
        r_ovf_p   <= w_ovf;
      end else if (r_state == CONVERT) begin
        r_scratch <= w_step;
        r_mag     <= r_mag << 1;
        r_cnt     <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_out_bcd  <= w_step;
          r_out_sign <= r_sign_p;
          r_overflow <= r_ovf_p;
        end
      end
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_out_valid;
  assign out_bcd   = r_out_bcd;
  assign out_sign  = r_out_sign;
  assign overflow  = r_overflow;

  // Display codes: scan from the top digit down tracking the leading-zero run
  bcd_digit_t [NUM_DIGITS:0] w_code;
  logic                      w_zero_run;

  always_comb begin
    w_code     = '0;
    w_zero_run = 1'b1;
    w_code[NUM_DIGITS] = r_out_sign ? SEG_MINUS : SEG_BLANK;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run && (r_out_bcd[4*i +: 4] == 4'd0);
      if (r_overflow)
        w_code[i] = SEG_MINUS;
      else if ((BLANK_LEADING != 0) && (i > 0) && w_zero_run)
        w_code[i] = SEG_BLANK;
      else
        w_code[i] = bcd_digit_t'(r_out_bcd[4*i +: 4]);
    end
  end

  for (genvar g = 0; g < int'(NUM_DIGITS) + 1; g++) begin : g_seg
    segdec u_segdec (
      .i_code (w_code[g]),
      .o_seg  (disp[g])
    );
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: three configurations, decimal reference
// model, expected results queued at accept and checked when out_valid fires.
module tb_bin_to_bcd_seq;

  typedef struct {
    logic [11:0] bcd;
    logic        sign;
    logic        ovf;
    logic [27:0] disp;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  v_in;
  logic [7:0]  d_in [3];
  logic [2:0]  rdy, ov, sg, of;
  logic [11:0] bcd  [3];
  logic [27:0] dsp  [3];

  logic [11:0]      bcd0, bcd1;
  logic [7:0]       bcd2;
  logic [3:0][6:0]  disp0, disp1;
  logic [2:0][6:0]  disp2;

  exp_t q0[$], q1[$], q2[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_seq #(.IN_WIDTH(8), .NUM_DIGITS(3), .SIGNED(1), .BLANK_LEADING(1)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(v_in[0]), .in_ready(rdy[0]), .in(d_in[0]),
    .out_valid(ov[0]), .out_bcd(bcd0), .out_sign(sg[0]), .overflow(of[0]), .disp(disp0));

  bin_to_bcd_seq #(.IN_WIDTH(8), .NUM_DIGITS(3), .SIGNED(0), .BLANK_LEADING(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(v_in[1]), .in_ready(rdy[1]), .in(d_in[1]),
    .out_valid(ov[1]), .out_bcd(bcd1), .out_sign(sg[1]), .overflow(of[1]), .disp(disp1));

  bin_to_bcd_seq #(.IN_WIDTH(8), .NUM_DIGITS(2), .SIGNED(1), .BLANK_LEADING(1)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(v_in[2]), .in_ready(rdy[2]), .in(d_in[2]),
    .out_valid(ov[2]), .out_bcd(bcd2), .out_sign(sg[2]), .overflow(of[2]), .disp(disp2));

  assign bcd[0] = bcd0;
  assign bcd[1] = bcd1;
  assign bcd[2] = 12'(bcd2);
  assign dsp[0] = disp0;
  assign dsp[1] = disp1;
  assign dsp[2] = 28'(disp2);

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;
      4'h3: return 7'h4F;  4'h4: return 7'h66;  4'h5: return 7'h6D;
      4'h6: return 7'h7D;  4'h7: return 7'h07;  4'h8: return 7'h7F;
      4'h9: return 7'h6F;  4'hA: return 7'h40;  default: return 7'h00;
    endcase
  endfunction

  // Decimal reference: sign/magnitude, truncated digits, blanking and dashes
  function automatic exp_t model(input int v, input bit sgn, input int nd);
    exp_t e;
    int mag, lim, t, p;
    logic [3:0] dg, code;
    e.sign = sgn && v[7];
    mag = e.sign ? 256 - v : v;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    e.ovf  = (mag >= lim);
    t      = mag % lim;
    e.bcd  = '0;
    e.disp = '0;
    p = 1;
    for (int d = 0; d < nd; d++) begin
      dg = 4'((t / p) % 10);
      e.bcd[4*d +: 4] = dg;
      if (e.ovf)                 code = 4'hA;
      else if (d > 0 && t < p)   code = 4'hF;
      else                       code = dg;
      e.disp[7*d +: 7] = seg_of(code);
      p = p * 10;
    end
    e.disp[7*nd +: 7] = seg_of(e.sign ? 4'hA : 4'hF);
    e.due = 0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] v, input int due);
    exp_t e;
    e = model(int'(v), k != 1, (k == 2) ? 2 : 3);
    e.due = due;
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Present one word when the DUT is ready; accepted on the following edge
  task automatic send(input int k, input logic [7:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (rdy[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_d%0d", k), 64'(rdy[k]), 64'd1);
    v_in[k] = 1'b1;
    d_in[k] = v;
    push(k, v, cyc + 1 + 8);
    @(negedge clk);
    v_in[k] = 1'b0;
    d_in[k] = 8'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
  endtask

  // Scoreboard: every out_valid must match the oldest outstanding expectation
  always @(negedge clk) begin : mon
    exp_t e;
    bit   have;
    for (int k = 0; k < 3; k++) begin
      if (ov[k] === 1'b1) begin
        have = 1'b0;
        case (k)
          0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        check($sformatf("valid_expected_d%0d", k), 64'(have), 64'd1);
        if (have) begin
          check($sformatf("latency_d%0d", k), 64'(cyc), 64'(e.due));
          check($sformatf("bcd_d%0d", k), 64'(bcd[k]), 64'(e.bcd));
          check($sformatf("sign_d%0d", k), 64'(sg[k]), 64'(e.sign));
          check($sformatf("ovf_d%0d", k), 64'(of[k]), 64'(e.ovf));
          check($sformatf("disp_d%0d", k), 64'(dsp[k]), 64'(e.disp));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t r;
    reset = 1'b1;
    v_in  = '0;
    for (int k = 0; k < 3; k++) d_in[k] = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state of all three configurations
    for (int k = 0; k < 3; k++) begin
      r = model(0, k != 1, (k == 2) ? 2 : 3);
      check($sformatf("rst_ready_d%0d", k), 64'(rdy[k]), 64'd1);
      check($sformatf("rst_valid_d%0d", k), 64'(ov[k]), 64'd0);
      check($sformatf("rst_bcd_d%0d", k), 64'(bcd[k]), 64'd0);
      check($sformatf("rst_sign_d%0d", k), 64'(sg[k]), 64'd0);
      check($sformatf("rst_ovf_d%0d", k), 64'(of[k]), 64'd0);
      check($sformatf("rst_disp_d%0d", k), 64'(dsp[k]), 64'(r.disp));
    end

    // Signed defaults: positive max, most negative, minus one
    send(0, 8'h7F);
    drain();
    send(0, 8'h80);
    send(0, 8'hFF);
    drain();

    // Unsigned: full scale and zero
    send(1, 8'hFF);
    send(1, 8'h00);
    drain();

    // Two digits: overflow then largest in-range value
    send(2, 8'd100);
    send(2, 8'd99);
    drain();

    // Back-to-back with in_valid held and input wiggling during conversion
    @(negedge clk);
    v_in[1] = 1'b1;
    d_in[1] = 8'd5;
    push(1, 8'd5, cyc + 1 + 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("busy_d1", 64'(rdy[1]), 64'd0);
      d_in[1] = 8'($urandom);
    end
    @(negedge clk);
    check("rearm_d1", 64'(rdy[1]), 64'd1);
    d_in[1] = 8'd250;
    push(1, 8'd250, cyc + 1 + 8);
    @(negedge clk);
    v_in[1] = 1'b0;
    d_in[1] = 8'($urandom);
    drain();

    // Reset in the third conversion cycle aborts without a result strobe
    send(0, 8'd42);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    q0.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", 64'(rdy[0]), 64'd1);
    check("abort_valid", 64'(ov[0]), 64'd0);
    check("abort_bcd", 64'(bcd[0]), 64'd0);
    check("abort_sign", 64'(sg[0]), 64'd0);
    repeat (12) @(negedge clk);
    send(0, 8'hC8);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
